// File: rtl/uart_text_buffer.sv
// Message store between the UART receiver and the LED scanner, with optional echo path.
// Build with UART_TEXT_ECHO_EN defined to include the echo FIFO and TX handshake FSM.
module uart_text_buffer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  FILL_CHAR  = 8'h20
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_char,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              clearing,
    output logic              echo_ovf
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        rd_char_q;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic              push;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        clr_cnt_d = clr_cnt_q;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q;
        mem_wdata = rx_byte;
        push      = 1'b0;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt_q;
                mem_wdata = FILL_CHAR;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = '0;
                end
            end
            default: begin
                if (rx_valid) begin
                    push = 1'b1;
                    if (rx_byte == 8'h0D) begin
                        wr_ptr_d = '0;
                    end else if (rx_byte == 8'h1B) begin
                        state_d   = S_CLEAR;
                        clr_cnt_d = '0;
                        wr_ptr_d  = '0;
                    end else if (rx_byte == 8'h08) begin
                        if (wr_ptr_q != '0) begin
                            wr_ptr_d  = wr_ptr_q - 1'b1;
                            mem_we    = 1'b1;
                            mem_waddr = wr_ptr_q - 1'b1;
                            mem_wdata = FILL_CHAR;
                        end
                    end else if (rx_byte >= 8'h20 && rx_byte <= 8'h7E) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            wr_ptr_q  <= '0;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Read-before-write RAM: a same-cycle write is not forwarded to rd_char.
    always_ff @(posedge clk_in) begin
        if (mem_we && !rst) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            rd_char_q <= FILL_CHAR;
        end else begin
            rd_char_q <= mem_q[rd_addr];
        end
    end

    assign rd_char  = rd_char_q;
    assign wr_ptr   = wr_ptr_q;
    assign clearing = (state_q == S_CLEAR);

`ifdef UART_TEXT_ECHO_EN
    localparam int unsigned FIFO_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [1:0] T_IDLE      = 2'd0;
    localparam logic [1:0] T_WAIT_BUSY = 2'd1;
    localparam logic [1:0] T_WAIT_DONE = 2'd2;

    logic [7:0]         fifo_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] fifo_wr_q, fifo_rd_q;
    logic [FIFO_AW:0]   fifo_cnt_q;
    logic [1:0]         tx_state_q, tx_state_d;
    logic [7:0]         tx_byte_q;
    logic               tx_start_q;
    logic               echo_ovf_q;
    logic               fifo_full, fifo_empty, pop, do_push;

    assign fifo_full  = (fifo_cnt_q == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    assign pop        = (tx_state_q == T_IDLE) && !fifo_empty && !tx_busy;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push    = push && (!fifo_full || pop);

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            T_IDLE:      if (pop) tx_state_d = T_WAIT_BUSY;
            T_WAIT_BUSY: if (tx_busy) tx_state_d = T_WAIT_DONE;
            T_WAIT_DONE: if (!tx_busy) tx_state_d = T_IDLE;
            default:     tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (do_push && !rst) begin
            fifo_q[fifo_wr_q] <= rx_byte;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
            fifo_cnt_q <= '0;
            tx_state_q <= T_IDLE;
            tx_byte_q  <= '0;
            tx_start_q <= 1'b0;
            echo_ovf_q <= 1'b0;
        end else begin
            if (do_push) fifo_wr_q <= fifo_wr_q + 1'b1;
            if (pop) begin
                fifo_rd_q <= fifo_rd_q + 1'b1;
                tx_byte_q <= fifo_q[fifo_rd_q];
            end
            fifo_cnt_q <= fifo_cnt_q + (FIFO_AW + 1)'(do_push) - (FIFO_AW + 1)'(pop);
            tx_state_q <= tx_state_d;
            tx_start_q <= pop;
            if (push && fifo_full && !pop) echo_ovf_q <= 1'b1;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;
    assign echo_ovf = echo_ovf_q;
`else
    logic unused_echo;
    assign unused_echo = tx_busy | push | (FIFO_DEPTH == 0);

    assign tx_start = 1'b0;
    assign tx_byte  = 8'h00;
    assign echo_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_text_buffer.sv
// Directed bench for uart_text_buffer; echo expectations follow UART_TEXT_ECHO_EN.
module tb_uart_text_buffer;

    logic       clk_in = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_char;
    logic [3:0] wr_ptr;
    logic       clearing;
    logic       echo_ovf;

    logic       hold_busy = 1'b0;
    logic       uart_busy = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] echo_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    assign tx_busy = hold_busy | uart_busy;

    uart_text_buffer #(
        .DEPTH(16),
        .ADDR_W(4),
        .FIFO_DEPTH(4),
        .FILL_CHAR(8'h20)
    ) dut (
        .clk_in(clk_in),
        .rst(rst),
        .rx_valid(rx_valid),
        .rx_byte(rx_byte),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_byte(tx_byte),
        .rd_addr(rd_addr),
        .rd_char(rd_char),
        .wr_ptr(wr_ptr),
        .clearing(clearing),
        .echo_ovf(echo_ovf)
    );

    always #5 clk_in = ~clk_in;

    // UART transmitter stand-in: captures each echoed byte, then stays busy for 4 cycles.
    always @(negedge clk_in) begin
        if (tx_start) begin
            echo_q.push_back(tx_byte);
            busy_cnt = 4;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        uart_busy = (busy_cnt != 0);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
    endtask

    task automatic send_spaced(input logic [7:0] b);
        send_byte(b);
        step(8);
    endtask

    task automatic read_char(input logic [3:0] a, output logic [7:0] c);
        rd_addr = a;
        @(negedge clk_in);
        c = rd_char;
    endtask

    task automatic test_reset;
        int cnt;
        logic [7:0] c;
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        n_checks++; if (clearing !== 1'b1) begin n_fail++; $display("FAIL reset_clearing: got %b expected 1", clearing); end
        n_checks++; if (wr_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_wr_ptr: got %0d expected 0", wr_ptr); end
        n_checks++; if (rd_char !== 8'h20) begin n_fail++; $display("FAIL reset_rd_char: got %h expected 20", rd_char); end
        n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        n_checks++; if (tx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
        n_checks++; if (echo_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_echo_ovf: got %b expected 0", echo_ovf); end
        cnt = 0;
        for (int i = 0; i < 40 && clearing === 1'b1; i++) begin
            cnt++;
            @(negedge clk_in);
        end
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL reset_clear_len: got %0d cycles expected 16", cnt); end
        for (int a = 0; a < 16; a++) begin
            read_char(4'(a), c);
            n_checks++; if (c !== 8'h20) begin n_fail++; $display("FAIL reset_mem[%0d]: got %h expected 20", a, c); end
        end
        n_checks++; if (wr_ptr !== 4'd0) begin n_fail++; $display("FAIL reset_wr_ptr_after: got %0d expected 0", wr_ptr); end
    endtask

    task automatic test_edit_echo;
        logic [7:0] c;
        logic [7:0] exp_e [4];
        exp_e[0] = 8'h48; exp_e[1] = 8'h49; exp_e[2] = 8'h0D; exp_e[3] = 8'h4A;
        echo_q.delete();
        send_byte(8'h48);
        send_byte(8'h49);
        send_byte(8'h0D);
        send_byte(8'h4A);
        n_checks++; if (wr_ptr !== 4'd1) begin n_fail++; $display("FAIL edit_wr_ptr: got %0d expected 1", wr_ptr); end
        read_char(4'd0, c);
        n_checks++; if (c !== 8'h4A) begin n_fail++; $display("FAIL edit_mem0: got %h expected 4a", c); end
        read_char(4'd1, c);
        n_checks++; if (c !== 8'h49) begin n_fail++; $display("FAIL edit_mem1: got %h expected 49", c); end
`ifdef UART_TEXT_ECHO_EN
        for (int i = 0; i < 300 && echo_q.size() < 4; i++) @(negedge clk_in);
        step(20);
        n_checks++;
        if (echo_q.size() != 4) begin
            n_fail++; $display("FAIL edit_echo_count: got %0d expected 4", echo_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (echo_q[i] !== exp_e[i]) begin n_fail++; $display("FAIL edit_echo[%0d]: got %h expected %h", i, echo_q[i], exp_e[i]); end
            end
        end
`else
        step(60);
        n_checks++; if (echo_q.size() != 0) begin n_fail++; $display("FAIL edit_no_echo: got %0d pulses expected 0", echo_q.size()); end
`endif
    endtask

    task automatic test_wrap;
        logic [7:0] c;
        echo_q.delete();
        send_spaced(8'h0D);
        for (int i = 0; i < 17; i++) send_spaced(8'(8'h41 + i));
        n_checks++; if (wr_ptr !== 4'd1) begin n_fail++; $display("FAIL wrap_wr_ptr: got %0d expected 1", wr_ptr); end
        read_char(4'd0, c);
        n_checks++; if (c !== 8'h51) begin n_fail++; $display("FAIL wrap_mem0: got %h expected 51", c); end
        read_char(4'd1, c);
        n_checks++; if (c !== 8'h42) begin n_fail++; $display("FAIL wrap_mem1: got %h expected 42", c); end
        read_char(4'd15, c);
        n_checks++; if (c !== 8'h50) begin n_fail++; $display("FAIL wrap_mem15: got %h expected 50", c); end
        n_checks++; if (echo_ovf !== 1'b0) begin n_fail++; $display("FAIL wrap_no_ovf: got %b expected 0", echo_ovf); end
`ifdef UART_TEXT_ECHO_EN
        n_checks++;
        if (echo_q.size() != 18) begin
            n_fail++; $display("FAIL wrap_echo_count: got %0d expected 18", echo_q.size());
        end else begin
            n_checks++; if (echo_q[0] !== 8'h0D) begin n_fail++; $display("FAIL wrap_echo[0]: got %h expected 0d", echo_q[0]); end
            for (int i = 1; i < 18; i++) begin
                n_checks++; if (echo_q[i] !== 8'(8'h40 + i)) begin n_fail++; $display("FAIL wrap_echo[%0d]: got %h expected %h", i, echo_q[i], 8'(8'h40 + i)); end
            end
        end
`endif
    endtask

    task automatic test_backspace;
        logic [7:0] c;
        send_spaced(8'h0D);
        send_spaced(8'h08);
        n_checks++; if (wr_ptr !== 4'd0) begin n_fail++; $display("FAIL bs_at0_wr_ptr: got %0d expected 0", wr_ptr); end
        read_char(4'd0, c);
        n_checks++; if (c !== 8'h51) begin n_fail++; $display("FAIL bs_at0_mem0: got %h expected 51", c); end
        send_spaced(8'h41);
        send_spaced(8'h42);
        send_spaced(8'h08);
        n_checks++; if (wr_ptr !== 4'd1) begin n_fail++; $display("FAIL bs_wr_ptr: got %0d expected 1", wr_ptr); end
        read_char(4'd1, c);
        n_checks++; if (c !== 8'h20) begin n_fail++; $display("FAIL bs_mem1: got %h expected 20", c); end
        read_char(4'd0, c);
        n_checks++; if (c !== 8'h41) begin n_fail++; $display("FAIL bs_mem0: got %h expected 41", c); end
        send_spaced(8'h1F);
        send_spaced(8'h7F);
        n_checks++; if (wr_ptr !== 4'd1) begin n_fail++; $display("FAIL ignore_wr_ptr: got %0d expected 1", wr_ptr); end
        read_char(4'd1, c);
        n_checks++; if (c !== 8'h20) begin n_fail++; $display("FAIL ignore_mem1: got %h expected 20", c); end
        send_spaced(8'h7E);
        send_spaced(8'h20);
        n_checks++; if (wr_ptr !== 4'd3) begin n_fail++; $display("FAIL edge_wr_ptr: got %0d expected 3", wr_ptr); end
        read_char(4'd1, c);
        n_checks++; if (c !== 8'h7E) begin n_fail++; $display("FAIL edge_mem1: got %h expected 7e", c); end
    endtask

    task automatic test_read_during_write;
        rd_addr  = 4'd3;
        rx_byte  = 8'h5A;
        rx_valid = 1'b1;
        @(negedge clk_in);
        rx_valid = 1'b0;
        n_checks++; if (rd_char !== 8'h44) begin n_fail++; $display("FAIL rdw_old: got %h expected 44", rd_char); end
        @(negedge clk_in);
        n_checks++; if (rd_char !== 8'h5A) begin n_fail++; $display("FAIL rdw_new: got %h expected 5a", rd_char); end
        n_checks++; if (wr_ptr !== 4'd4) begin n_fail++; $display("FAIL rdw_wr_ptr: got %0d expected 4", wr_ptr); end
        step(8);
    endtask

    task automatic test_overflow;
        step(10);
        echo_q.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i));
        step(4);
`ifdef UART_TEXT_ECHO_EN
        n_checks++; if (echo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", echo_ovf); end
        n_checks++; if (echo_q.size() != 0) begin n_fail++; $display("FAIL ovf_held: got %0d echoes expected 0", echo_q.size()); end
        hold_busy = 1'b0;
        for (int i = 0; i < 300 && echo_q.size() < 4; i++) @(negedge clk_in);
        step(40);
        n_checks++;
        if (echo_q.size() != 4) begin
            n_fail++; $display("FAIL ovf_echo_count: got %0d expected 4", echo_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (echo_q[i] !== 8'(8'h30 + i)) begin n_fail++; $display("FAIL ovf_echo[%0d]: got %h expected %h", i, echo_q[i], 8'(8'h30 + i)); end
            end
        end
        n_checks++; if (echo_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", echo_ovf); end
`else
        hold_busy = 1'b0;
        step(40);
        n_checks++; if (echo_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_off: got %b expected 0", echo_ovf); end
        n_checks++; if (echo_q.size() != 0) begin n_fail++; $display("FAIL ovf_no_echo: got %0d expected 0", echo_q.size()); end
`endif
    endtask

    task automatic test_esc_clear;
        int cnt;
        logic [7:0] c;
        echo_q.delete();
        cnt = 0;
        send_byte(8'h1B);
        if (clearing === 1'b1) cnt++;
        @(negedge clk_in);
        if (clearing === 1'b1) cnt++;
        @(negedge clk_in);
        if (clearing === 1'b1) cnt++;
        send_byte(8'h58);
        for (int i = 0; i < 40 && clearing === 1'b1; i++) begin
            cnt++;
            @(negedge clk_in);
        end
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL esc_clear_len: got %0d cycles expected 16", cnt); end
        n_checks++; if (wr_ptr !== 4'd0) begin n_fail++; $display("FAIL esc_wr_ptr: got %0d expected 0", wr_ptr); end
        for (int a = 0; a < 16; a++) begin
            read_char(4'(a), c);
            n_checks++; if (c !== 8'h20) begin n_fail++; $display("FAIL esc_mem[%0d]: got %h expected 20", a, c); end
        end
        step(20);
`ifdef UART_TEXT_ECHO_EN
        n_checks++;
        if (echo_q.size() != 1) begin
            n_fail++; $display("FAIL esc_echo_count: got %0d expected 1", echo_q.size());
        end else begin
            n_checks++; if (echo_q[0] !== 8'h1B) begin n_fail++; $display("FAIL esc_echo: got %h expected 1b", echo_q[0]); end
        end
`else
        n_checks++; if (echo_q.size() != 0) begin n_fail++; $display("FAIL esc_no_echo: got %0d expected 0", echo_q.size()); end
`endif
    endtask

    task automatic test_reset_mid;
        int cnt;
        logic [7:0] c;
        echo_q.delete();
        hold_busy = 1'b1;
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h1B);
        step(5);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        hold_busy = 1'b0;
        n_checks++; if (echo_ovf !== 1'b0) begin n_fail++; $display("FAIL rmid_ovf_cleared: got %b expected 0", echo_ovf); end
        n_checks++; if (rd_char !== 8'h20) begin n_fail++; $display("FAIL rmid_rd_char: got %h expected 20", rd_char); end
        cnt = 0;
        for (int i = 0; i < 40 && clearing === 1'b1; i++) begin
            cnt++;
            @(negedge clk_in);
        end
        n_checks++; if (cnt != 16) begin n_fail++; $display("FAIL rmid_clear_len: got %0d cycles expected 16", cnt); end
        step(40);
        n_checks++; if (echo_q.size() != 0) begin n_fail++; $display("FAIL rmid_fifo_discard: got %0d echoes expected 0", echo_q.size()); end
        read_char(4'd0, c);
        n_checks++; if (c !== 8'h20) begin n_fail++; $display("FAIL rmid_mem0: got %h expected 20", c); end
        read_char(4'd1, c);
        n_checks++; if (c !== 8'h20) begin n_fail++; $display("FAIL rmid_mem1: got %h expected 20", c); end
        n_checks++; if (wr_ptr !== 4'd0) begin n_fail++; $display("FAIL rmid_wr_ptr: got %0d expected 0", wr_ptr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk_in);
        test_reset();
        test_edit_echo();
        test_wrap();
        test_backspace();
        test_read_during_write();
        test_overflow();
        test_esc_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
